// File: rtl/castlab_of_collect_pkg.sv
// castlab_of_collect_pkg: shared FSM state type and default sizes for the output-feature deskew collector
package castlab_of_collect_pkg;

    localparam int OF_FIFO_DEPTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } of_coll_state_t;

endpackage

// File: rtl/castlab_sync_fifo.sv
// castlab_sync_fifo: single-clock FIFO; a push while full is accepted only if a pop happens in the same cycle
module castlab_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic             wr_en;
    logic             rd_en;

    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign wr_en = push & (~full | pop);
    assign rd_en = pop & ~empty;
    assign rdata = mem[rp];

    // Storage array; only written on an accepted push, never reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wp] <= wdata;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= wp + AW'(wr_en);
            rp    <= rp + AW'(rd_en);
            count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end

endmodule

// File: rtl/castlab_of_deskew_collector.sv
// castlab_of_deskew_collector: realigns skewed systolic-array columns into rows, queues them and tracks the drain.
// Optional build macro CASTLAB_OF_RELU_EN clamps negative samples to zero as rows enter the FIFO.
`ifndef CFG_OF_NUM
`define CFG_OF_NUM 4
`endif
`ifndef CFG_OF_PORT
`define CFG_OF_PORT 2
`endif
`ifndef CFG_OF_BITWIDTH
`define CFG_OF_BITWIDTH 8
`endif
module castlab_of_deskew_collector
    import castlab_of_collect_pkg::*;
#(
    parameter int OF_NUM      = `CFG_OF_NUM,
    parameter int OF_PORT     = `CFG_OF_PORT,
    parameter int OF_BITWIDTH = `CFG_OF_BITWIDTH,
    parameter int FIFO_DEPTH  = OF_FIFO_DEPTH_DEF
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic [OF_NUM-1:0][OF_PORT-1:0][OF_BITWIDTH-1:0]  sa_o_data,
    input  logic [OF_NUM-1:0][OF_PORT-1:0]                   sa_o_valid,
    input  logic                                             sa_done,
    output logic [OF_NUM-1:0][OF_PORT-1:0][OF_BITWIDTH-1:0]  wr_o_data,
    output logic                                             wr_o_valid,
    input  logic                                             wr_i_ready,
    output logic                                             busy,
    output logic                                             done,
    output logic                                             overflow,
    output logic                                             align_err
);

    localparam int W = OF_NUM * OF_PORT * OF_BITWIDTH;

    of_coll_state_t state;

    logic [OF_NUM-1:0][OF_PORT-1:0][OF_BITWIDTH-1:0] dsk_d;
    logic [OF_NUM-1:0][OF_PORT-1:0][OF_BITWIDTH-1:0] row_d;
    logic [OF_NUM-1:0][OF_PORT-1:0]                  dsk_v;
    logic [OF_NUM-1:0]                               col_busy;
    logic [W-1:0]                                    fifo_q;
    logic [$clog2(FIFO_DEPTH):0]                     fifo_count;
    logic                                            fifo_full;
    logic                                            fifo_empty;
    logic                                            row_valid;
    logic                                            row_part;
    logic                                            pop;
    logic                                            clr;
    logic                                            drain_idle;

    for (genvar j = 0; j < OF_NUM; j++) begin : g_col
        localparam int D = OF_NUM - 1 - j;
        if (D == 0) begin : g_pass
            assign dsk_d[j]    = sa_o_data[j];
            assign dsk_v[j]    = sa_o_valid[j];
            assign col_busy[j] = 1'b0;
        end else begin : g_dly
            logic [D-1:0][OF_PORT-1:0][OF_BITWIDTH-1:0] sd;
            logic [D-1:0][OF_PORT-1:0]                  sv;
            // Early columns wait D cycles so they line up with the last column.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sv <= '0;
                end else begin
                    sv[0] <= sa_o_valid[j];
                    sd[0] <= sa_o_data[j];
                    for (int k = 1; k < D; k++) begin
                        sv[k] <= sv[k-1];
                        sd[k] <= sd[k-1];
                    end
                end
            end
            assign dsk_d[j]    = sd[D-1];
            assign dsk_v[j]    = sv[D-1];
            assign col_busy[j] = |sv;
        end
    end

    assign row_valid  = &dsk_v;
    assign row_part   = |dsk_v & ~row_valid;
    assign wr_o_valid = ~fifo_empty;
    assign wr_o_data  = wr_o_valid ? fifo_q : '0;
    assign pop        = wr_o_valid & wr_i_ready;
    assign clr        = (state == IDLE) & |sa_o_valid;
    assign drain_idle = ~|sa_o_valid & ~|col_busy & (fifo_count == '0);

`ifdef CASTLAB_OF_RELU_EN
    // Negative samples are clamped on the way into the FIFO, adding no register stage.
    always_comb begin
        row_d = dsk_d;
        for (int j = 0; j < OF_NUM; j++)
            for (int p = 0; p < OF_PORT; p++)
                row_d[j][p] = dsk_d[j][p][OF_BITWIDTH-1] ? '0 : dsk_d[j][p];
    end
`else
    assign row_d = dsk_d;
`endif

    castlab_sync_fifo #(
        .WIDTH (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (row_valid),
        .pop   (pop),
        .wdata (row_d),
        .rdata (fifo_q),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Sticky error flags, cleared when a new run starts; a fresh error wins over the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            align_err <= 1'b0;
        end else begin
            overflow  <= (overflow & ~clr) | (row_valid & fifo_full & ~pop);
            align_err <= (align_err & ~clr) | row_part;
        end
    end

    // Run-control FSM with registered busy/done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|sa_o_valid) begin
                    state <= RUN;
                    busy  <= 1'b1;
                end
                RUN: if (sa_done) state <= DRAIN;
                DRAIN: if (drain_idle) begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
